// File: rtl/tap_tempo.sv
// Tap-tempo front end: debounces a tap button, times the gap between taps in ms and
// divides it into a BPM value for the metronome. Define TAP_AVG_EN to average the last 4 gaps.
module tap_tempo #(
   parameter int CLK_HZ      = 25000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int TIMEOUT_MS  = 2000,
   parameter int MIN_BPM     = 30,
   parameter int MAX_BPM     = 250,
   parameter int DEFAULT_BPM = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tap,
   output logic [7:0] speed,
   output logic       speed_valid,
   output logic       tap_led,
   output logic       busy
);

   localparam int PRESCALE = CLK_HZ / 1000;
   localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);

   typedef enum logic [1:0] {S_IDLE, S_TIMING, S_DIVIDE, S_UPDATE} state_t;

   state_t          state_reg, state_next;
   logic [PS_W-1:0] ps_cnt_reg;
   logic            tick;
   logic [1:0]      sync_reg;
   logic            db_level_reg, db_prev_reg;
   logic [DB_W-1:0] db_cnt_reg;
   logic            tap_evt;
   logic            led_reg;
   logic [11:0]     ms_cnt_reg;
   logic [11:0]     interval_reg;
   logic            start_div, timeout;
   logic [13:0]     divisor_sum, divisor;
   logic [17:0]     dividend_start;
   logic [17:0]     quo_reg;
   logic [13:0]     rem_reg;
   logic [14:0]     trial;
   logic [4:0]      div_cnt_reg;
   logic [7:0]      clamped;
   logic [7:0]      speed_reg;
   logic            speed_valid_reg;

   // 1 ms tick prescaler
   assign tick = (ps_cnt_reg == PS_W'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ps_cnt_reg <= '0;
      else if (tick) ps_cnt_reg <= '0;
      else           ps_cnt_reg <= ps_cnt_reg + 1'b1;
   end

   // Synchronizer and debouncer: level flips only after DEBOUNCE_MS ticks at the new value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg     <= '0;
         db_level_reg <= 1'b0;
         db_prev_reg  <= 1'b0;
         db_cnt_reg   <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], tap};
         db_prev_reg <= db_level_reg;
         if (sync_reg[1] == db_level_reg) begin
            db_cnt_reg <= '0;
         end else if (tick) begin
            if (db_cnt_reg == DB_W'(DEBOUNCE_MS - 1)) begin
               db_level_reg <= sync_reg[1];
               db_cnt_reg   <= '0;
            end else begin
               db_cnt_reg <= db_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign tap_evt = db_level_reg & ~db_prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_reg    <= 1'b0;
         ms_cnt_reg <= '0;
      end else begin
         if (tap_evt) led_reg <= ~led_reg;
         if (tap_evt)
            ms_cnt_reg <= '0;
         else if (tick && ms_cnt_reg != 12'hFFF)
            ms_cnt_reg <= ms_cnt_reg + 12'd1;
      end
   end

   // Control FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      start_div  = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         S_IDLE:   if (tap_evt) state_next = S_TIMING;
         S_TIMING: begin
            if (tap_evt) begin
               start_div  = 1'b1;
               state_next = S_DIVIDE;
            end else if (ms_cnt_reg >= 12'(TIMEOUT_MS)) begin
               timeout    = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_DIVIDE: if (div_cnt_reg == 5'd17) state_next = S_UPDATE;
         S_UPDATE: state_next = S_TIMING;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         interval_reg <= '0;
      else if (start_div) interval_reg <= ms_cnt_reg;
      else if (timeout)   interval_reg <= '0;
   end

`ifdef TAP_AVG_EN
   // Older intervals; unfilled entries stay zero so the sum covers exactly n entries
   logic [11:0] hist_reg [3];
   logic [2:0]  n_reg, n_next;

   assign n_next = (n_reg == 3'd4) ? 3'd4 : n_reg + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_reg <= '0;
         for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
      end else if (timeout) begin
         n_reg <= '0;
         for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
      end else if (start_div) begin
         n_reg       <= n_next;
         hist_reg[0] <= interval_reg;
         for (int i = 1; i < 3; i++) hist_reg[i] <= hist_reg[i-1];
      end
   end

   assign divisor_sum    = {2'b00, interval_reg} + {2'b00, hist_reg[0]}
                         + {2'b00, hist_reg[1]}  + {2'b00, hist_reg[2]};
   assign dividend_start = 18'(60000 * int'(n_next));
`else
   assign divisor_sum    = {2'b00, interval_reg};
   assign dividend_start = 18'(60000);
`endif

   assign divisor = (divisor_sum == 14'd0) ? 14'd1 : divisor_sum;

   // Restoring divider: dividend shifts out of quo_reg while quotient bits shift in
   assign trial = {rem_reg, quo_reg[17]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_reg     <= '0;
         rem_reg     <= '0;
         div_cnt_reg <= '0;
      end else if (start_div) begin
         quo_reg     <= dividend_start;
         rem_reg     <= '0;
         div_cnt_reg <= '0;
      end else if (state_reg == S_DIVIDE) begin
         div_cnt_reg <= div_cnt_reg + 5'd1;
         if (trial >= {1'b0, divisor}) begin
            rem_reg <= 14'(trial - {1'b0, divisor});
            quo_reg <= {quo_reg[16:0], 1'b1};
         end else begin
            rem_reg <= trial[13:0];
            quo_reg <= {quo_reg[16:0], 1'b0};
         end
      end
   end

   always_comb begin
      if (quo_reg < 18'(MIN_BPM))      clamped = 8'(MIN_BPM);
      else if (quo_reg > 18'(MAX_BPM)) clamped = 8'(MAX_BPM);
      else                             clamped = quo_reg[7:0];
   end

   // speed and its valid pulse are registered together out of UPDATE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_reg       <= 8'(DEFAULT_BPM);
         speed_valid_reg <= 1'b0;
      end else begin
         speed_valid_reg <= (state_reg == S_UPDATE);
         if (state_reg == S_UPDATE) speed_reg <= clamped;
      end
   end

   assign speed       = speed_reg;
   assign speed_valid = speed_valid_reg;
   assign tap_led     = led_reg;
   assign busy        = (state_reg == S_DIVIDE);

endmodule
